dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//   Data-memory responder at the far end of the EX/MEM memory-control interface.
//   Consumes mem_read/mem_write plus address and store data from the EX/MEM register.
//   Services each request with a fixed multi-cycle latency from an internal word array.
//   Drives stall back to the pipeline so the EX/MEM register holds until the access completes.
// PARAMETERS
//   DEPTH_WORDS  32  number of 32-bit words; power of 2, >= 2
//   LATENCY      3   cycles spent in ACCESS per request; >= 1
// PORTS
//   clk        in   1   clock; all state updates on posedge
//   rst        in   1   synchronous, active-high reset
//   mem_read   in   1   load request, from EX/MEM
//   mem_write  in   1   store request, from EX/MEM
//   addr       in   32  byte address (ALU result)
//   wdata      in   32  store data
//   rdata      out  32  load data; valid in DONE, held until next load completes
//   stall      out  1   1 = pipeline must hold EX/MEM and earlier stages
//   err        out  1   1-cycle pulse in DONE for a faulted request
// BEHAVIOUR
//   Reset (rst=1 at posedge):
//     - state=IDLE, rdata=0, err=0, counter=0.
//     - An in-flight access is aborted; its write is never performed.
//     - Array contents are not cleared.
//   req = mem_read | mem_write.
//   Word index = addr[2 +: log2(DEPTH_WORDS)]; upper address bits ignored (wraps modulo depth).
//   FSM:
//     IDLE:
//       - stall = req (combinational, same cycle).
//       - If req: latch addr, wdata and op; counter <= LATENCY-1; go ACCESS.
//     ACCESS:
//       - stall = 1.
//       - If counter != 0: decrement.
//       - If counter == 0: perform op on latched values; go DONE.
//         Load updates rdata; store writes the array.
//     DONE:
//       - stall = 0; the pipeline advances at this edge.
//       - Inputs ignored (same instruction still presented); go IDLE.
//   Timing: request first seen in cycle T.
//     - stall high T .. T+LATENCY.
//     - DONE at T+LATENCY+1 with rdata valid.
//     - A new request is accepted no earlier than T+LATENCY+2.
//   mem_read and mem_write both high: treated as a store; err pulses in DONE.
//   Requests are sampled only in IDLE; input changes during ACCESS are ignored (values latched).
//   Store then load of the same word: the load returns the new data.
//   rst asserted in DONE or ACCESS: next cycle is IDLE; stall follows req.
// CONFIGURATION
//   DMEM_STRICT_ALIGN_EN defined:
//     - addr[1:0] != 0 is a fault: no write, rdata <= 0, err pulses in DONE.
//     - Latency is unchanged.
//   Not defined:
//     - addr[1:0] ignored (word-aligned access).
//     - err pulses only on a simultaneous read+write request.
// TESTING (LATENCY=3, DEPTH_WORDS=32)
//   1. rst=1 for 2 cycles, then idle -> rdata=0, stall=0, err=0.
//   2. Store wdata=0xDEADBEEF at addr=0x10, hold until stall=0
//      -> stall=1 for 4 cycles, then 1 DONE cycle with stall=0.
//   3. Load addr=0x10 -> rdata=0xDEADBEEF in DONE (cycle T+4); rdata unchanged afterwards.
//   4. Store 0x12345678 at addr=0x90 (wraps to index 4), load addr=0x10
//      -> rdata=0x12345678.
//   5. rst pulse in 2nd ACCESS cycle of store 0xCAFEF00D to 0x20, then load 0x20
//      -> old value returned, not 0xCAFEF00D.
//   6. mem_read=mem_write=1, addr=0x08, wdata=0x5
//      -> err=1 for exactly the DONE cycle; a later load of 0x08 returns 0x5.
//      With DMEM_STRICT_ALIGN_EN: store to addr=0x0A
//      -> err pulse, word at index 2 unchanged.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: services EX/MEM loads/stores with a fixed latency and stalls the pipeline.
// Optional DMEM_STRICT_ALIGN_EN: misaligned addresses fault (no write, rdata cleared, err pulse).
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 32,
  parameter int unsigned LATENCY     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        err
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StDone   = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic [IdxW-1:0] idx_q;
  logic [31:0]     wdata_q;
  logic            is_write_q;
  logic            fault_q;
  logic            misalign_q;
  logic [31:0]     rdata_q;
  logic [31:0]     mem_q [DEPTH_WORDS];

  logic req;
  logic misalign;
  logic do_op;
  logic unused_addr;

  assign req = mem_read | mem_write;

`ifdef DMEM_STRICT_ALIGN_EN
  assign misalign = (addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // Upper address bits wrap; low bits only matter in the strict-alignment build.
  assign unused_addr = ^addr;

  assign do_op = (state_q == StAccess) && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      StIdle: begin
        stall = req;
        if (req) state_d = StAccess;
      end
      StAccess: begin
        stall = 1'b1;
        if (cnt_q == '0) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && req) begin
        idx_q      <= addr[2 +: IdxW];
        wdata_q    <= wdata;
        is_write_q <= mem_write;
        misalign_q <= misalign;
        fault_q    <= (mem_read & mem_write) | misalign;
        cnt_q      <= CntW'(LATENCY - 1);
      end else if (state_q == StAccess && cnt_q != '0) begin
        cnt_q <= cnt_q - CntW'(1);
      end
      if (do_op) begin
        if (misalign_q) begin
          rdata_q <= '0;
        end else if (!is_write_q) begin
          rdata_q <= mem_q[idx_q];
        end
      end
    end
  end

  // Array is never reset; a reset during ACCESS suppresses the pending write.
  always_ff @(posedge clk) begin
    if (!rst && do_op && is_write_q && !misalign_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign rdata = rdata_q;
  assign err   = (state_q == StDone) && fault_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed steps plus random traffic against an array model.
module tb_dmem_responder;

  localparam int unsigned Depth = 32;
  localparam int unsigned Lat   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        stall;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] model_mem [Depth];
  logic [31:0] model_rdata = '0;

  dmem_responder #(
    .DEPTH_WORDS(Depth),
    .LATENCY    (Lat)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .stall    (stall),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_misaligned(input logic [31:0] a);
`ifdef DMEM_STRICT_ALIGN_EN
    return a[1:0] != 2'b00;
`else
    return (a & 32'h0) != 0;
`endif
  endfunction

  // Called at posedge+1 with the DUT idle; returns at posedge+1 after the DONE cycle.
  task automatic op(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    int unsigned idx;
    bit          mis;
    bit          fault;
    idx   = (a / 4) % Depth;
    mis   = is_misaligned(a);
    fault = (rd && wr) || mis;
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = d;
    for (int c = 0; c <= Lat; c++) begin
      @(negedge clk);
      check("stall_busy", {31'b0, stall}, 32'd1);
      check("err_busy", {31'b0, err}, 32'd0);
      check("rdata_hold", rdata, model_rdata);
      @(posedge clk);
      #1;
      // Inputs must be ignored once the request is latched.
      mem_read  = 1'($urandom);
      mem_write = 1'($urandom);
      addr      = $urandom;
      wdata     = $urandom;
    end
    if (mis) begin
      model_rdata = '0;
    end else if (wr) begin
      model_mem[idx] = d;
    end else begin
      model_rdata = model_mem[idx];
    end
    @(negedge clk);
    check("stall_done", {31'b0, stall}, 32'd0);
    check("err_done", {31'b0, err}, {31'b0, fault});
    check("rdata_done", rdata, model_rdata);
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    check("stall_idle", {31'b0, stall}, 32'd0);
    check("err_idle", {31'b0, err}, 32'd0);
    check("rdata_idle", rdata, model_rdata);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Step 1: reset for two cycles.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_rdata = '0;
    idle_cycle();

    // Step 2/3: store then load the same word.
    op(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    op(1'b1, 1'b0, 32'h10, 32'h0);
    idle_cycle();
    idle_cycle();

    // Give every word a known value so later loads are predictable.
    for (int i = 0; i < int'(Depth); i++) begin
      op(1'b0, 1'b1, 32'(i * 4), $urandom);
    end

    // Step 4: aliasing through upper address bits.
    op(1'b0, 1'b1, 32'h90, 32'h12345678);
    op(1'b1, 1'b0, 32'h10, 32'h0);
    check("alias_load", rdata, 32'h12345678);

    // Step 5: reset in the second ACCESS cycle aborts the store.
    op(1'b0, 1'b1, 32'h20, 32'h11112222);
    mem_read  = 1'b0;
    mem_write = 1'b1;
    addr      = 32'h20;
    wdata     = 32'hCAFEF00D;
    @(negedge clk);
    check("rst_stall_req", {31'b0, stall}, 32'd1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_stall_access", {31'b0, stall}, 32'd1);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    mem_write = 1'b0;
    model_rdata = '0;
    @(negedge clk);
    check("rst_stall_follows_req", {31'b0, stall}, 32'd0);
    check("rst_rdata_clear", rdata, 32'h0);
    @(posedge clk);
    #1;
    op(1'b1, 1'b0, 32'h20, 32'h0);
    check("abort_old_value", rdata, 32'h11112222);

    // Step 6: simultaneous read+write acts as a store with an err pulse.
    op(1'b1, 1'b1, 32'h08, 32'h5);
    idle_cycle();
    op(1'b1, 1'b0, 32'h08, 32'h0);
    check("rw_store_value", rdata, 32'h5);
`ifdef DMEM_STRICT_ALIGN_EN
    op(1'b0, 1'b1, 32'h0A, 32'hBADBAD00);
    op(1'b1, 1'b0, 32'h08, 32'h0);
    check("misalign_no_write", rdata, 32'h5);
`endif

    // Random traffic, including back-to-back requests and low address bits.
    for (int n = 0; n < 300; n++) begin
      int unsigned kind;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      a    = $urandom;
      if (kind <= 3) op(1'b1, 1'b0, a, $urandom);
      else if (kind <= 7) op(1'b0, 1'b1, a, $urandom);
      else if (kind == 8) op(1'b1, 1'b1, a, $urandom);
      else idle_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
